// File: rtl/hfrv_trace_pkg.sv
// Shared types for the HF-RISCV data-bus tracer.
//  trace_rec_t : one captured bus transaction, packed MSB-first as
//                {ts, addr, data, be, is_write}; this is the trc_data layout.
//  TRC_TSW     : timestamp width the record type is built for.
//  TRACE_W     : packed record width.
package hfrv_trace_pkg;

    localparam int TRC_TSW = 32;
    localparam int TRACE_W = TRC_TSW + 69;

    typedef struct packed {
        logic [TRC_TSW-1:0] ts;
        logic [31:0]        addr;
        logic [31:0]        data;
        logic [3:0]         be;
        logic               is_write;
    } trace_rec_t;

    // Any asserted byte enable marks a write; all-zero marks a read.
    function automatic logic be_is_write(input logic [3:0] be);
        return |be;
    endfunction

endpackage

// File: rtl/hfrv_trace_fifo.sv
// Synchronous flop-based FIFO for trace records.
//  clk, rst : clock, async active-high reset (pointers and level only)
//  push/din : write request and data; ignored when full unless popping
//  pop      : read request; ignored when empty
//  dout     : head entry (valid whenever level != 0)
//  level    : occupancy 0..DEPTH
module hfrv_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          full, empty, push_ok, pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop & ~empty;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

endmodule

// File: rtl/hfrv_bus_tracer.sv
// Data-bus capture stage for the HF-RISCV core.
//  Samples each accepted bus access into a one-entry capture stage (S1),
//  completes it (writes next edge, reads on the first unstalled edge with
//  bus_rdata), stamps it with a free-running cycle count and queues it for
//  the monitor over a valid/ready stream.
//  clk, rst                      : clock, async active-high reset
//  bus_access/stall/addr/be/wdata/rdata : core data-bus observation
//  clear                         : sync clear of drop_count / overflow
//  trc_valid/ready/data          : record stream {ts, addr, data, be, is_write}
//  trc_level                     : FIFO occupancy
//  drop_count, overflow          : records lost to a full FIFO
module hfrv_bus_tracer
    import hfrv_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TSW   = 32,
    parameter int DCW   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bus_access,
    input  logic                     bus_stall,
    input  logic [31:0]              bus_addr,
    input  logic [3:0]               bus_be,
    input  logic [31:0]              bus_wdata,
    input  logic [31:0]              bus_rdata,
    input  logic                     clear,
    input  logic                     trc_ready,
    output logic                     trc_valid,
    output logic [TSW+68:0]          trc_data,
    output logic [$clog2(DEPTH):0]   trc_level,
    output logic [DCW-1:0]           drop_count,
    output logic                     overflow
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int RW = TSW + 69;

    logic [TSW-1:0] cyc;

    // Capture stage S1
    logic           s1_vld, s1_wr;
    logic [TSW-1:0] s1_ts;
    logic [31:0]    s1_addr, s1_data;
    logic [3:0]     s1_be;

    logic           accept, push, pop, full, drop;
    logic [RW-1:0]  push_rec;

    assign accept = bus_access & ~bus_stall;
    // Writes already carry their data; reads wait for the first unstalled edge.
    assign push   = s1_vld & (s1_wr | ~bus_stall);
    assign push_rec = {s1_ts, s1_addr, (s1_wr ? s1_data : bus_rdata), s1_be, s1_wr};

    assign pop  = trc_valid & trc_ready;
    assign full = (trc_level == LW'(DEPTH));
    assign drop = push & full & ~pop;

    assign trc_valid = (trc_level != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 1'b1;
    end

    // Reload takes priority over retire so back-to-back accesses sustain one per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_wr   <= 1'b0;
            s1_ts   <= '0;
            s1_addr <= '0;
            s1_data <= '0;
            s1_be   <= '0;
        end else if (accept) begin
            s1_vld  <= 1'b1;
            s1_wr   <= be_is_write(bus_be);
            s1_ts   <= cyc;
            s1_addr <= bus_addr;
            s1_be   <= bus_be;
            if (be_is_write(bus_be)) s1_data <= bus_wdata;
        end else if (push) begin
            s1_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

    hfrv_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_rec),
        .dout  (trc_data),
        .level (trc_level)
    );

endmodule

// File: tb/tb_hfrv_bus_tracer.sv
module tb_hfrv_bus_tracer;
    import hfrv_trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int DCW   = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  bus_access, bus_stall, clear, trc_ready;
    logic [31:0]           bus_addr, bus_wdata, bus_rdata;
    logic [3:0]            bus_be;
    logic                  trc_valid, overflow;
    logic [TRACE_W-1:0]    trc_data;
    logic [4:0]            trc_level;
    logic [DCW-1:0]        drop_count;

    int n_chk  = 0;
    int n_fail = 0;
    logic [TRACE_W-1:0] exp_q [$];
    logic [31:0] tb_cyc;

    hfrv_bus_tracer #(.DEPTH(DEPTH), .TSW(TRC_TSW), .DCW(DCW)) dut (
        .clk(clk), .rst(rst), .bus_access(bus_access), .bus_stall(bus_stall),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .clear(clear), .trc_ready(trc_ready),
        .trc_valid(trc_valid), .trc_data(trc_data), .trc_level(trc_level),
        .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference cycle count: edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 32'd0;
        else     tb_cyc <= tb_cyc + 32'd1;
    end

    function automatic logic [TRACE_W-1:0] mk(input logic [31:0] ts, input logic [31:0] a,
                                              input logic [31:0] d, input logic [3:0] be);
        trace_rec_t r;
        r.ts = ts; r.addr = a; r.data = d; r.be = be; r.is_write = (be != 4'h0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: every handshake must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && trc_valid && trc_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_record: got %h expected none", trc_data);
            end else begin
                chk("record", 128'(trc_data), 128'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // One accepted write; expected record queued only if it should survive.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input bit keep);
        bus_access = 1'b1; bus_stall = 1'b0; bus_addr = a; bus_wdata = d; bus_be = be;
        if (keep) exp_q.push_back(mk(tb_cyc, a, d, be));
        step();
        bus_access = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        trc_ready = 1'b1;
        while (trc_level != 0 && k < 200) begin step(); k++; end
        step();
        chk("drain_level", 128'(trc_level), 128'd0);
        chk("drain_queue", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        rst = 1'b1; bus_access = 0; bus_stall = 0; bus_addr = 0; bus_be = 0;
        bus_wdata = 0; bus_rdata = 0; clear = 0; trc_ready = 0;
        #1;
        chk("rst_valid", 128'(trc_valid), 128'd0);
        chk("rst_level", 128'(trc_level), 128'd0);
        chk("rst_drop",  128'(drop_count), 128'd0);
        chk("rst_ovf",   128'(overflow), 128'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Single write: valid after the second edge
        trc_ready = 1'b1;
        wr(32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 1);
        chk("lat_edge1_valid", 128'(trc_valid), 128'd0);
        step();
        chk("lat_edge2_valid", 128'(trc_valid), 128'd1);
        step(); step();

        // Read held by 3 stall cycles
        bus_access = 1'b1; bus_stall = 1'b0; bus_addr = 32'h100; bus_be = 4'h0;
        exp_q.push_back(mk(tb_cyc, 32'h100, 32'h1234_5678, 4'h0));
        step();
        bus_access = 1'b0; bus_stall = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("read_stalled_valid", 128'(trc_valid), 128'd0);
        end
        bus_stall = 1'b0; bus_rdata = 32'h1234_5678;
        step();
        bus_rdata = 32'h0;
        step(); step(); step();
        chk("read_one_record", 128'(exp_q.size()), 128'd0);
        chk("read_level", 128'(trc_level), 128'd0);

        // 20 back-to-back writes into a stopped consumer
        trc_ready = 1'b0;
        for (int i = 0; i < 20; i++)
            wr(32'h2000 + 32'(4*i), 32'hA500_0000 + 32'(i), 4'hF, i < 16);
        step();
        chk("fill_level", 128'(trc_level), 128'd16);
        chk("fill_drop",  128'(drop_count), 128'd4);
        chk("fill_ovf",   128'(overflow), 128'd1);

        clear = 1'b1; step(); clear = 1'b0;
        chk("clear_drop",  128'(drop_count), 128'd0);
        chk("clear_ovf",   128'(overflow), 128'd0);
        chk("clear_level", 128'(trc_level), 128'd16);

        wr(32'h2100, 32'h1111_1111, 4'h1, 0);
        step();
        chk("redrop_drop", 128'(drop_count), 128'd1);
        chk("redrop_ovf",  128'(overflow), 128'd1);

        // Clear on the same edge as a drop wins
        wr(32'h2104, 32'h2222_2222, 4'h2, 0);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clrdrop_drop", 128'(drop_count), 128'd0);
        chk("clrdrop_ovf",  128'(overflow), 128'd0);
        chk("clrdrop_level", 128'(trc_level), 128'd16);

        drain();

        // Full FIFO with push and pop every edge
        trc_ready = 1'b0;
        for (int i = 0; i < 26; i++) begin
            logic [3:0] be;
            be = (i % 4 == 0) ? 4'hF : (i % 4 == 1) ? 4'h3 : (i % 4 == 2) ? 4'hC : 4'h8;
            if (i == 17) trc_ready = 1'b1;
            wr(32'h3000 + 32'(4*i), 32'h5A00_0000 + 32'(i), be, 1);
            if (i >= 16) chk("full_pp_level", 128'(trc_level), 128'd16);
        end
        step();
        chk("full_pp_level_last", 128'(trc_level), 128'd16);
        chk("full_pp_drop", 128'(drop_count), 128'd0);
        chk("full_pp_ovf",  128'(overflow), 128'd0);
        drain();

        // Reset while a read is pending, with one record already queued
        trc_ready = 1'b0;
        wr(32'h4000, 32'h7777_7777, 4'hF, 0);
        bus_access = 1'b1; bus_addr = 32'h4004; bus_be = 4'h0;
        step();
        bus_access = 1'b0; bus_stall = 1'b1;
        step();
        chk("pre_rst_level", 128'(trc_level), 128'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 128'(trc_valid), 128'd0);
        chk("arst_level", 128'(trc_level), 128'd0);
        chk("arst_drop",  128'(drop_count), 128'd0);
        chk("arst_ovf",   128'(overflow), 128'd0);
        step(); step();
        rst = 1'b0;
        bus_stall = 1'b0; bus_rdata = 32'hCAFE_F00D; trc_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_valid", 128'(trc_valid), 128'd0);
        end
        chk("post_rst_queue", 128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
